// File: rtl/fetch_unit.sv
// Instruction fetch unit: keeps one memory request in flight and buffers fetched
// words in a 2-entry FIFO that feeds the decode stage, with redirect/flush support.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2,
        S_IDLE = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] pc0_q, pc0_d, inst0_q, inst0_d;
    logic [31:0] pc1_q, pc1_d, inst1_q, inst1_d;

    logic        req_s;
    logic        gnt_s;
    logic        pop_s;
    logic        push_s;
    logic [1:0]  occ_s;
    logic [31:0] push_pc_s;
    logic        unused_s;

    // REQ state is only entered with room in the FIFO; the count term is a guard
    assign req_s     = (state_q == S_REQ) && (count_q < 2'd2);
    assign gnt_s     = req_s && imem_gnt;
    assign pop_s     = (count_q != 2'd0) && id_ready;
    assign push_s    = (state_q == S_WAIT) && imem_rvalid && !redirect;
    // fetch_pc already advanced at grant, so the outstanding address sits 4 behind it
    assign push_pc_s = fetch_pc_q - 32'd4;
    assign unused_s  = ^redirect_pc[1:0];

    assign imem_req  = req_s && reset_n;
    assign imem_addr = fetch_pc_q;
    assign id_valid  = (count_q != 2'd0);
    assign id_pc     = pc0_q;
    assign id_inst   = inst0_q;

    // Next-state and fetch address; redirect takes priority over everything else
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            case (state_q)
                S_REQ, S_IDLE: state_d = gnt_s ? S_DROP : S_REQ;
                S_WAIT:        state_d = imem_rvalid ? S_REQ : S_DROP;
                S_DROP:        state_d = S_DROP;
                default:       state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (gnt_s) begin
                        state_d    = S_WAIT;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state_d = (count_d < 2'd2) ? S_REQ : S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_DROP:  state_d = imem_rvalid ? S_REQ : S_DROP;
                S_IDLE:  state_d = (count_d < 2'd2) ? S_REQ : S_IDLE;
                default: state_d = S_REQ;
            endcase
        end
    end

    // FIFO update: shift on pop, then write the response behind the surviving entries
    always_comb begin
        count_d = count_q;
        pc0_d   = pc0_q;
        inst0_d = inst0_q;
        pc1_d   = pc1_q;
        inst1_d = inst1_q;
        occ_s   = count_q - {1'b0, pop_s};
        if (redirect) begin
            count_d = 2'd0;
        end else begin
            pc0_d   = pop_s ? pc1_q : pc0_q;
            inst0_d = pop_s ? inst1_q : inst0_q;
            if (push_s) begin
                case (occ_s)
                    2'd0: begin
                        pc0_d   = push_pc_s;
                        inst0_d = imem_rdata;
                    end
                    2'd1: begin
                        pc1_d   = push_pc_s;
                        inst1_d = imem_rdata;
                    end
                    default: begin
                        pc1_d   = pc1_q;
                        inst1_d = inst1_q;
                    end
                endcase
                count_d = (occ_s == 2'd2) ? 2'd2 : (occ_s + 2'd1);
            end else begin
                count_d = occ_s;
            end
        end
    end

    // Control state registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_REQ;
            fetch_pc_q <= RESET_PC;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc0_q   <= 32'd0;
            inst0_q <= 32'd0;
            pc1_q   <= 32'd0;
            inst1_q <= 32'd0;
        end else begin
            pc0_q   <= pc0_d;
            inst0_q <= inst0_d;
            pc1_q   <= pc1_d;
            inst1_q <= inst1_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit, plus a reset-during-WAIT sequence
// and a second instance that starts at the top of the address space.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        imem_gnt, imem_rvalid, redirect, id_ready;
    logic [31:0] imem_rdata, redirect_pc;
    logic        imem_req, id_valid;
    logic [31:0] imem_addr, id_pc, id_inst;
    logic        w_req, w_id_valid;
    logic [31:0] w_addr, w_id_pc, w_id_inst;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
        .clock(clock), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .id_ready(id_ready),
        .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clock(clock), .reset_n(reset_n),
        .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .id_ready(id_ready),
        .id_valid(w_id_valid), .id_pc(w_id_pc), .id_inst(w_id_inst)
    );

    typedef struct {
        logic        rst_n;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_idv;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    localparam int NV = 31;
    vec_t vecs [NV];

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic g, input logic rv, input logic [31:0] rd,
                                input logic rdr, input logic [31:0] rp, input logic ry,
                                input logic er, input logic [31:0] ea, input logic ev,
                                input logic [31:0] ep, input logic [31:0] ei);
        vec_t v;
        v.rst_n = rst; v.gnt = g; v.rvalid = rv; v.rdata = rd; v.redir = rdr; v.rpc = rp; v.rdy = ry;
        v.e_req = er; v.e_addr = ea; v.e_idv = ev; v.e_pc = ep; v.e_inst = ei;
        return v;
    endfunction

    initial begin
        reset_n     = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        id_ready    = 1'b0;

        // Each row: inputs driven this cycle | outputs expected before this cycle's edge
        //            rst   gnt   rv    rdata          redir rpc            rdy     req   addr           idv   pc             inst
        vecs[0]  = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1,   1'b1, 32'h0000_0000, 1'b0, 32'h0,         32'h0);
        vecs[1]  = mk(1'b1, 1'b0, 1'b1, 32'h0000_0013, 1'b0, 32'h0,         1'b1,   1'b0, 32'h0000_0004, 1'b0, 32'h0,         32'h0);
        vecs[2]  = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1,   1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000, 32'h0000_0013);
        vecs[3]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0,   1'b1, 32'h0000_0004, 1'b0, 32'h0,         32'h0);
        vecs[4]  = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0,   1'b0, 32'h0000_0000, 1'b0, 32'h0,         32'h0);
        vecs[5]  = mk(1'b1, 1'b1, 1'b1, 32'h1111_0000, 1'b0, 32'h0,         1'b0,   1'b1, 32'h0000_0000, 1'b0, 32'h0,         32'h0);
        vecs[6]  = mk(1'b1, 1'b1, 1'b1, 32'h2222_0000, 1'b0, 32'h0,         1'b0,   1'b0, 32'h0000_0004, 1'b0, 32'h0,         32'h0);
        vecs[7]  = mk(1'b1, 1'b1, 1'b1, 32'h3333_0000, 1'b0, 32'h0,         1'b0,   1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000, 32'h2222_0000);
        vecs[8]  = mk(1'b1, 1'b1, 1'b1, 32'h4444_0004, 1'b0, 32'h0,         1'b0,   1'b0, 32'h0000_0008, 1'b1, 32'h0000_0000, 32'h2222_0000);
        vecs[9]  = mk(1'b1, 1'b1, 1'b1, 32'h5555_0000, 1'b0, 32'h0,         1'b0,   1'b0, 32'h0000_0008, 1'b1, 32'h0000_0000, 32'h2222_0000);
        vecs[10] = mk(1'b1, 1'b1, 1'b1, 32'h6666_0000, 1'b0, 32'h0,         1'b1,   1'b0, 32'h0000_0008, 1'b1, 32'h0000_0000, 32'h2222_0000);
        vecs[11] = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0,   1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004, 32'h4444_0004);
        vecs[12] = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0,   1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004, 32'h4444_0004);
        vecs[13] = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0,   1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004, 32'h4444_0004);
        vecs[14] = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0103, 1'b0,   1'b0, 32'h0000_000C, 1'b1, 32'h0000_0004, 32'h4444_0004);
        vecs[15] = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0,   1'b0, 32'h0000_0100, 1'b0, 32'h0,         32'h0);
        vecs[16] = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0,   1'b0, 32'h0000_0100, 1'b0, 32'h0,         32'h0);
        vecs[17] = mk(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0,   1'b0, 32'h0000_0100, 1'b0, 32'h0,         32'h0);
        vecs[18] = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1,   1'b1, 32'h0000_0100, 1'b0, 32'h0,         32'h0);
        vecs[19] = mk(1'b1, 1'b0, 1'b1, 32'h0000_0093, 1'b0, 32'h0,         1'b0,   1'b0, 32'h0000_0104, 1'b0, 32'h0,         32'h0);
        vecs[20] = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0,   1'b1, 32'h0000_0104, 1'b1, 32'h0000_0100, 32'h0000_0093);
        vecs[21] = mk(1'b1, 1'b0, 1'b1, 32'hBADB_AD00, 1'b1, 32'h0000_0203, 1'b1,   1'b0, 32'h0000_0108, 1'b1, 32'h0000_0100, 32'h0000_0093);
        vecs[22] = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1,   1'b1, 32'h0000_0200, 1'b0, 32'h0,         32'h0);
        vecs[23] = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0300, 1'b0,   1'b1, 32'h0000_0200, 1'b0, 32'h0,         32'h0);
        vecs[24] = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0404, 1'b0,   1'b0, 32'h0000_0300, 1'b0, 32'h0,         32'h0);
        vecs[25] = mk(1'b1, 1'b0, 1'b1, 32'h0000_0001, 1'b0, 32'h0,         1'b0,   1'b0, 32'h0000_0404, 1'b0, 32'h0,         32'h0);
        vecs[26] = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_050E, 1'b0,   1'b1, 32'h0000_0404, 1'b0, 32'h0,         32'h0);
        vecs[27] = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0,   1'b1, 32'h0000_050C, 1'b0, 32'h0,         32'h0);
        vecs[28] = mk(1'b1, 1'b0, 1'b1, 32'hCAFE_0001, 1'b0, 32'h0,         1'b0,   1'b0, 32'h0000_0510, 1'b0, 32'h0,         32'h0);
        vecs[29] = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0600, 1'b1,   1'b1, 32'h0000_0510, 1'b1, 32'h0000_050C, 32'hCAFE_0001);
        vecs[30] = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0,   1'b1, 32'h0000_0600, 1'b0, 32'h0,         32'h0);

        repeat (2) @(negedge clock);
        #1;
        check1 ("rst_req",       imem_req,   1'b0);
        check32("rst_addr",      imem_addr,  32'h0000_0000);
        check1 ("rst_idv",       id_valid,   1'b0);
        check32("rst_id_pc",     id_pc,      32'h0000_0000);
        check32("rst_id_inst",   id_inst,    32'h0000_0000);
        check1 ("rst_wrap_req",  w_req,      1'b0);
        check32("rst_wrap_addr", w_addr,     32'hFFFF_FFFC);
        check1 ("rst_wrap_idv",  w_id_valid, 1'b0);
        check32("rst_wrap_pc",   w_id_pc,    32'h0000_0000);
        check32("rst_wrap_inst", w_id_inst,  32'h0000_0000);

        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clock);
            #1;
            check1 ($sformatf("v%0d_req", i),  imem_req,  vecs[i].e_req);
            check32($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
            check1 ($sformatf("v%0d_idv", i),  id_valid,  vecs[i].e_idv);
            if (vecs[i].e_idv) begin
                check32($sformatf("v%0d_id_pc", i),   id_pc,   vecs[i].e_pc);
                check32($sformatf("v%0d_id_inst", i), id_inst, vecs[i].e_inst);
            end
            if (i == 0) check32("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
            if (i == 1) check32("wrap_second_addr", w_addr, 32'h0000_0000);
            reset_n     = vecs[i].rst_n;
            imem_gnt    = vecs[i].gnt;
            imem_rvalid = vecs[i].rvalid;
            imem_rdata  = vecs[i].rdata;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            id_ready    = vecs[i].rdy;
        end

        // Reset asserted while a granted request is outstanding; its late response must vanish
        @(negedge clock);
        #1;
        check1 ("rw_pre_req",  imem_req,  1'b1);
        check32("rw_pre_addr", imem_addr, 32'h0000_0600);
        imem_gnt = 1'b1;
        @(negedge clock);
        #1;
        check1 ("rw_wait_req",  imem_req,  1'b0);
        check32("rw_wait_addr", imem_addr, 32'h0000_0604);
        imem_gnt = 1'b0;
        reset_n  = 1'b0;
        #1;
        check1 ("rw_in_rst_req",  imem_req,  1'b0);
        check32("rw_in_rst_addr", imem_addr, 32'h0000_0000);
        check1 ("rw_in_rst_idv",  id_valid,  1'b0);
        @(negedge clock);
        #1;
        reset_n     = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        @(negedge clock);
        #1;
        check1 ("rw_post_req",  imem_req,  1'b1);
        check32("rw_post_addr", imem_addr, 32'h0000_0000);
        check1 ("rw_post_idv",  id_valid,  1'b0);
        imem_rvalid = 1'b0;
        @(negedge clock);
        #1;
        check1 ("rw_late_req",  imem_req,  1'b1);
        check32("rw_late_addr", imem_addr, 32'h0000_0000);
        check1 ("rw_late_idv",  id_valid,  1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
